// File: rtl/mips_pkg.sv
// Shared widths and ALU opcode encodings for the MIPS pipeline.
package mips_pkg;

  localparam int NB_REG      = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int NB_ALUOP    = 5;
  localparam int NB_SHAMT    = 5;

  localparam logic [NB_ALUOP-1:0] ALU_ADD  = 5'd0;
  localparam logic [NB_ALUOP-1:0] ALU_ADDU = 5'd1;
  localparam logic [NB_ALUOP-1:0] ALU_SUB  = 5'd2;
  localparam logic [NB_ALUOP-1:0] ALU_SUBU = 5'd3;
  localparam logic [NB_ALUOP-1:0] ALU_AND  = 5'd4;
  localparam logic [NB_ALUOP-1:0] ALU_OR   = 5'd5;
  localparam logic [NB_ALUOP-1:0] ALU_XOR  = 5'd6;
  localparam logic [NB_ALUOP-1:0] ALU_NOR  = 5'd7;
  localparam logic [NB_ALUOP-1:0] ALU_SLT  = 5'd8;
  localparam logic [NB_ALUOP-1:0] ALU_SLTU = 5'd9;
  localparam logic [NB_ALUOP-1:0] ALU_SLL  = 5'd10;
  localparam logic [NB_ALUOP-1:0] ALU_SRL  = 5'd11;
  localparam logic [NB_ALUOP-1:0] ALU_SRA  = 5'd12;
  localparam logic [NB_ALUOP-1:0] ALU_SLLV = 5'd13;
  localparam logic [NB_ALUOP-1:0] ALU_SRLV = 5'd14;
  localparam logic [NB_ALUOP-1:0] ALU_SRAV = 5'd15;
  localparam logic [NB_ALUOP-1:0] ALU_LUI  = 5'd16;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: arithmetic, logic, compares, shifts and LUI, with signed overflow.
module alu_core #(
  parameter int NB_REG   = mips_pkg::NB_REG,
  parameter int NB_ALUOP = mips_pkg::NB_ALUOP,
  parameter int NB_SHAMT = mips_pkg::NB_SHAMT
) (
  input  logic [NB_REG-1:0]   i_a,
  input  logic [NB_REG-1:0]   i_b,
  input  logic [NB_SHAMT-1:0] i_shamt,
  input  logic [NB_ALUOP-1:0] i_op,
  output logic [NB_REG-1:0]   o_result,
  output logic                o_ovf
);
  import mips_pkg::*;

  logic [NB_REG-1:0]   sum;
  logic [NB_REG-1:0]   diff;
  logic [NB_SHAMT-1:0] var_sh;

  assign sum    = i_a + i_b;
  assign diff   = i_a - i_b;
  assign var_sh = i_a[NB_SHAMT-1:0];

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result = sum;
        o_ovf    = (i_a[NB_REG-1] == i_b[NB_REG-1]) && (sum[NB_REG-1] != i_a[NB_REG-1]);
      end
      ALU_ADDU: o_result = sum;
      ALU_SUB: begin
        // B's sign is inverted for subtraction, so the operands "match" when their signs differ.
        o_result = diff;
        o_ovf    = (i_a[NB_REG-1] != i_b[NB_REG-1]) && (diff[NB_REG-1] != i_a[NB_REG-1]);
      end
      ALU_SUBU: o_result = diff;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(NB_REG-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(NB_REG-1){1'b0}}, (i_a < i_b)};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
      ALU_SLLV: o_result = i_b << var_sh;
      ALU_SRLV: o_result = i_b >> var_sh;
      ALU_SRAV: o_result = $signed(i_b) >>> var_sh;
      ALU_LUI:  o_result = {i_b[NB_REG/2-1:0], {(NB_REG/2){1'b0}}};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding muxes, ALU, link mux and the EX/MEM pipeline register.
module execute_stage #(
  parameter int NB_REG      = mips_pkg::NB_REG,
  parameter int NB_REG_ADDR = mips_pkg::NB_REG_ADDR,
  parameter int NB_ALUOP    = mips_pkg::NB_ALUOP,
  parameter int NB_SHAMT    = mips_pkg::NB_SHAMT
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_flush,
  input  logic [NB_REG-1:0]      i_data_a,
  input  logic [NB_REG-1:0]      i_data_b,
  input  logic                   i_fwd_mux_a,
  input  logic                   i_fwd_mux_b,
  input  logic [NB_REG-1:0]      i_fwd_data_a,
  input  logic [NB_REG-1:0]      i_fwd_data_b,
  input  logic [NB_REG-1:0]      i_imm,
  input  logic [NB_SHAMT-1:0]    i_shamt,
  input  logic                   i_use_imm,
  input  logic [NB_ALUOP-1:0]    i_alu_op,
  input  logic                   i_link,
  input  logic [NB_REG-1:0]      i_pc_plus8,
  input  logic [NB_REG_ADDR-1:0] i_rd,
  input  logic                   i_we,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  output logic [NB_REG-1:0]      o_fwd_data_ex,
  output logic [NB_REG_ADDR-1:0] o_fwd_rd_ex,
  output logic                   o_fwd_we_ex,
  output logic [NB_REG-1:0]      o_result,
  output logic [NB_REG-1:0]      o_store_data,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic                   o_we,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_overflow
);

  logic [NB_REG-1:0] op_a;
  logic [NB_REG-1:0] rtv;
  logic [NB_REG-1:0] op_b;
  logic [NB_REG-1:0] alu_result;
  logic [NB_REG-1:0] ex_result;
  logic              ovf;

  assign op_a      = i_fwd_mux_a ? i_fwd_data_a : i_data_a;
  assign rtv       = i_fwd_mux_b ? i_fwd_data_b : i_data_b;
  assign op_b      = i_use_imm ? i_imm : rtv;
  assign ex_result = i_link ? i_pc_plus8 : alu_result;

  alu_core #(
    .NB_REG   (NB_REG),
    .NB_ALUOP (NB_ALUOP),
    .NB_SHAMT (NB_SHAMT)
  ) u_alu_core (
    .i_a      (op_a),
    .i_b      (op_b),
    .i_shamt  (i_shamt),
    .i_op     (i_alu_op),
    .o_result (alu_result),
    .o_ovf    (ovf)
  );

  // A load's result is an address, never data, so it must not be forwarded.
  assign o_fwd_data_ex = ex_result;
  assign o_fwd_rd_ex   = i_rd;
  assign o_fwd_we_ex   = i_we & ~i_mem_read & ~i_flush & ~ovf;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_result     <= '0;
      o_store_data <= '0;
      o_rd         <= '0;
      o_we         <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_overflow   <= 1'b0;
    end else if (i_valid) begin
      o_result     <= ex_result;
      o_store_data <= rtv;
      o_rd         <= i_rd;
      o_we         <= i_we & ~ovf & ~i_flush;
      o_mem_read   <= i_mem_read & ~i_flush;
      o_mem_write  <= i_mem_write & ~i_flush;
      o_overflow   <= ovf & ~i_flush;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle sequences, random vs model.
module tb_execute_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset, valid, flush;
  logic [31:0] data_a, data_b, fwd_data_a, fwd_data_b, imm, pc_plus8;
  logic        fwd_mux_a, fwd_mux_b, use_imm, link, we, mem_read, mem_write;
  logic [4:0]  shamt, alu_op, rd;
  logic [31:0] fwd_data_ex, q_result, q_store;
  logic [4:0]  fwd_rd_ex, q_rd;
  logic        fwd_we_ex, q_we, q_mr, q_mw, q_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  execute_stage dut (
    .i_clock(clock), .i_reset(reset), .i_valid(valid), .i_flush(flush),
    .i_data_a(data_a), .i_data_b(data_b), .i_fwd_mux_a(fwd_mux_a), .i_fwd_mux_b(fwd_mux_b),
    .i_fwd_data_a(fwd_data_a), .i_fwd_data_b(fwd_data_b), .i_imm(imm), .i_shamt(shamt),
    .i_use_imm(use_imm), .i_alu_op(alu_op), .i_link(link), .i_pc_plus8(pc_plus8),
    .i_rd(rd), .i_we(we), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .o_fwd_data_ex(fwd_data_ex), .o_fwd_rd_ex(fwd_rd_ex), .o_fwd_we_ex(fwd_we_ex),
    .o_result(q_result), .o_store_data(q_store), .o_rd(q_rd), .o_we(q_we),
    .o_mem_read(q_mr), .o_mem_write(q_mw), .o_overflow(q_ovf)
  );

  typedef struct {
    logic [31:0] da, db, fa, fb, imm, pc8;
    logic        ma, mb, ui, lk, we, mr, mw, fl;
    logic [4:0]  sh, op, rd;
  } in_t;

  typedef struct {
    logic [31:0] fwd;
    logic        fwd_we;
    logic [31:0] res, st;
    logic [4:0]  rd;
    logic        we, mr, mw, ovf;
  } mdl_t;

  typedef struct {
    string       name;
    in_t         i;
    logic [31:0] res;
    logic        we, ovf, fwd_we;
  } vec_t;

  function automatic in_t blank();
    in_t t;
    t.da = 0; t.db = 0; t.fa = 0; t.fb = 0; t.imm = 0; t.pc8 = 0;
    t.ma = 0; t.mb = 0; t.ui = 0; t.lk = 0; t.we = 0; t.mr = 0; t.mw = 0; t.fl = 0;
    t.sh = 0; t.op = ALU_ADDU; t.rd = 0;
    return t;
  endfunction

  task automatic apply(input in_t t);
    data_a = t.da; data_b = t.db; fwd_data_a = t.fa; fwd_data_b = t.fb;
    imm = t.imm; pc_plus8 = t.pc8; fwd_mux_a = t.ma; fwd_mux_b = t.mb;
    use_imm = t.ui; link = t.lk; we = t.we; mem_read = t.mr; mem_write = t.mw;
    flush = t.fl; shamt = t.sh; alu_op = t.op; rd = t.rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: operations expressed as plain integer arithmetic.
  function automatic mdl_t model(input in_t t);
    mdl_t   m;
    logic [31:0] a, b, rtv, r, ones;
    longint s;
    logic   ov;
    int     sa;
    a   = t.ma ? t.fa : t.da;
    rtv = t.mb ? t.fb : t.db;
    b   = t.ui ? t.imm : rtv;
    ov  = 1'b0;
    ones = 32'hFFFF_FFFF;
    sa  = int'(a % 32);
    case (t.op)
      ALU_ADD, ALU_ADDU: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ov = (t.op == ALU_ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      ALU_SUB, ALU_SUBU: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ov = (t.op == ALU_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      ALU_SLL:  r = b * (32'd1 << t.sh);
      ALU_SRL:  r = b / (32'd1 << t.sh);
      ALU_SRA:  begin r = b >> t.sh; if (b[31]) r = r | ~(ones >> t.sh); end
      ALU_SLLV: r = b * (32'd1 << sa);
      ALU_SRLV: r = b / (32'd1 << sa);
      ALU_SRAV: begin r = b >> sa; if (b[31]) r = r | ~(ones >> sa); end
      ALU_LUI:  r = (b % 65536) * 65536;
      default:  r = 0;
    endcase
    if (t.lk) r = t.pc8;
    m.fwd    = r;
    m.fwd_we = t.we && !t.mr && !t.fl && !ov;
    m.res    = r;
    m.st     = rtv;
    m.rd     = t.rd;
    m.we     = t.we && !ov && !t.fl;
    m.mr     = t.mr && !t.fl;
    m.mw     = t.mw && !t.fl;
    m.ovf    = ov && !t.fl;
    return m;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t t;
    t.da = pick(); t.db = pick(); t.fa = pick(); t.fb = pick();
    t.imm = $urandom; t.pc8 = $urandom;
    t.ma = 1'($urandom_range(0, 1)); t.mb = 1'($urandom_range(0, 1));
    t.ui = 1'($urandom_range(0, 1)); t.we = 1'($urandom_range(0, 1));
    t.lk = ($urandom_range(0, 7) == 0);
    t.mr = ($urandom_range(0, 3) == 0);
    t.mw = ($urandom_range(0, 3) == 0);
    t.fl = ($urandom_range(0, 7) == 0);
    t.sh = 5'($urandom_range(0, 31));
    t.op = 5'($urandom_range(0, 16));
    t.rd = 5'($urandom_range(0, 31));
    // Keep link away from ADD/SUB so a stale opcode cannot raise overflow on a jump.
    if (t.lk && (t.op == ALU_ADD || t.op == ALU_SUB)) t.op = ALU_AND;
    return t;
  endfunction

  vec_t vecs[13];
  in_t  v;
  mdl_t exp_q, m;

  initial begin
    v = blank(); v.op = ALU_ADD; v.da = 5; v.db = 7; v.we = 1; v.rd = 2;
    vecs[0] = '{"add_5_7", v, 32'd12, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_SUB; v.ma = 1; v.fa = 32'h10; v.da = 32'h99; v.db = 1; v.we = 1;
    vecs[1] = '{"sub_fwd_a", v, 32'h0F, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_ADD; v.da = 32'h7FFF_FFFF; v.db = 1; v.we = 1;
    vecs[2] = '{"add_ovf", v, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    v.op = ALU_ADDU;
    vecs[3] = '{"addu_no_ovf", v, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_SRA; v.db = 32'h8000_0000; v.sh = 4; v.we = 1;
    vecs[4] = '{"sra", v, 32'hF800_0000, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_SLTU; v.da = 32'hFFFF_FFFF; v.db = 1; v.we = 1;
    vecs[5] = '{"sltu", v, 32'd0, 1'b1, 1'b0, 1'b1};
    v.op = ALU_SLT;
    vecs[6] = '{"slt", v, 32'd1, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_LUI; v.ui = 1; v.imm = 32'h1234; v.we = 1;
    vecs[7] = '{"lui", v, 32'h1234_0000, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_SUB; v.da = 32'h8000_0000; v.db = 1; v.we = 1;
    vecs[8] = '{"sub_ovf", v, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    v = blank(); v.op = ALU_SRAV; v.da = 32'd36; v.db = 32'h8000_0000; v.we = 1;
    vecs[9] = '{"srav", v, 32'hF800_0000, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_NOR; v.we = 1;
    vecs[10] = '{"nor", v, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
    v = blank(); v.lk = 1; v.pc8 = 32'h40; v.da = 3; v.db = 4; v.we = 1; v.rd = 31;
    vecs[11] = '{"jal_link", v, 32'h40, 1'b1, 1'b0, 1'b1};
    v = blank(); v.op = ALU_ADD; v.mb = 1; v.fb = 3; v.db = 100; v.da = 2; v.we = 1;
    vecs[12] = '{"add_fwd_b", v, 32'd5, 1'b1, 1'b0, 1'b1};

    // Reset with every input driven nonzero.
    v = blank();
    v.da = 1; v.db = 2; v.fa = 3; v.fb = 4; v.imm = 5; v.pc8 = 6; v.ma = 1; v.mb = 1;
    v.ui = 1; v.lk = 1; v.we = 1; v.mr = 1; v.mw = 1; v.sh = 3; v.op = ALU_ADD; v.rd = 7;
    apply(v); reset = 1; valid = 1;
    tick(); tick();
    chk("rst_result", q_result, 0); chk("rst_store", q_store, 0); chk("rst_rd", 32'(q_rd), 0);
    chk("rst_we", 32'(q_we), 0); chk("rst_mr", 32'(q_mr), 0); chk("rst_mw", 32'(q_mw), 0);
    chk("rst_ovf", 32'(q_ovf), 0);
    reset = 0;

    foreach (vecs[k]) begin
      apply(vecs[k].i);
      #1;
      chk({vecs[k].name, "_fwd_data"}, fwd_data_ex, vecs[k].res);
      chk({vecs[k].name, "_fwd_we"}, 32'(fwd_we_ex), 32'(vecs[k].fwd_we));
      tick();
      chk({vecs[k].name, "_result"}, q_result, vecs[k].res);
      chk({vecs[k].name, "_we"}, 32'(q_we), 32'(vecs[k].we));
      chk({vecs[k].name, "_ovf"}, 32'(q_ovf), 32'(vecs[k].ovf));
    end

    // Load: address not forwarded, but registered with mem_read and we.
    v = blank(); v.op = ALU_ADDU; v.da = 32'h100; v.ui = 1; v.imm = 4; v.we = 1; v.mr = 1; v.rd = 3;
    apply(v); #1;
    chk("load_fwd_we", 32'(fwd_we_ex), 0);
    tick();
    chk("load_result", q_result, 32'h104); chk("load_mr", 32'(q_mr), 1); chk("load_we", 32'(q_we), 1);
    // Flushed instruction (overflowing ADD with all controls set) becomes a bubble.
    v = blank(); v.op = ALU_ADD; v.da = 32'h7FFF_FFFF; v.db = 1; v.we = 1; v.mr = 1; v.mw = 1;
    v.fl = 1;
    apply(v); #1;
    chk("flush_fwd_we", 32'(fwd_we_ex), 0);
    tick();
    chk("flush_we", 32'(q_we), 0); chk("flush_mr", 32'(q_mr), 0);
    chk("flush_mw", 32'(q_mw), 0); chk("flush_ovf", 32'(q_ovf), 0);

    // Hold: commit a known instruction, then stall 3 cycles with changing inputs.
    v = blank(); v.op = ALU_ADD; v.da = 5; v.db = 7; v.we = 1; v.rd = 9;
    apply(v); tick();
    valid = 0;
    for (int c = 0; c < 3; c++) begin
      v = rand_in();
      apply(v); #1;
      m = model(v);
      chk("hold_fwd_data", fwd_data_ex, m.fwd);
      chk("hold_fwd_rd", 32'(fwd_rd_ex), 32'(m.rd));
      tick();
      chk("hold_result", q_result, 12); chk("hold_store", q_store, 7);
      chk("hold_rd", 32'(q_rd), 9); chk("hold_we", 32'(q_we), 1);
    end
    valid = 1;

    // Reset mid-stream wins over a valid instruction.
    v = blank(); v.op = ALU_ADDU; v.da = 1; v.db = 2; v.we = 1; v.mw = 1; v.rd = 4;
    apply(v); reset = 1; tick();
    chk("midrst_result", q_result, 0); chk("midrst_we", 32'(q_we), 0);
    chk("midrst_mw", 32'(q_mw), 0); chk("midrst_rd", 32'(q_rd), 0);
    reset = 0;
    exp_q = model(blank());
    exp_q.res = 0; exp_q.st = 0; exp_q.rd = 0; exp_q.we = 0; exp_q.mr = 0; exp_q.mw = 0;
    exp_q.ovf = 0;

    for (int n = 0; n < 400; n++) begin
      v = rand_in();
      valid = ($urandom_range(0, 7) != 0);
      apply(v); #1;
      m = model(v);
      chk("rnd_fwd_data", fwd_data_ex, m.fwd);
      chk("rnd_fwd_rd", 32'(fwd_rd_ex), 32'(m.rd));
      chk("rnd_fwd_we", 32'(fwd_we_ex), 32'(m.fwd_we));
      tick();
      if (valid) exp_q = m;
      chk("rnd_result", q_result, exp_q.res); chk("rnd_store", q_store, exp_q.st);
      chk("rnd_rd", 32'(q_rd), 32'(exp_q.rd)); chk("rnd_we", 32'(q_we), 32'(exp_q.we));
      chk("rnd_mr", 32'(q_mr), 32'(exp_q.mr)); chk("rnd_mw", 32'(q_mw), 32'(exp_q.mw));
      chk("rnd_ovf", 32'(q_ovf), 32'(exp_q.ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
